veritune_resampler: RTL and testbench
=====================================

# veritune_resampler

Pitch-shift engine for Veritune. It runs while the top-level state machine sits in SHIFT. It reads the recorded clip from the sample RAM, resamples it by a fixed-point ratio derived from `Freq` using a phase accumulator and linear interpolation, and writes the result to the playback RAM. It pulses `Done_Shift` on completion, which moves the state machine from SHIFT to PLAY.

## Interface
- `ADDR_W`, 17: sample address width (2^17 sample buffers).
- `DATA_W`, 16: signed PCM sample width.
- `FRAC_W`, 6: fractional bits of the step ratio; unity step = 2^FRAC_W = 64.
- `Clk`  in  1: system clock, rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `Start`  in  1: begin a pass; sampled only in IDLE.
- `Length`  in  ADDR_W: index of the last recorded sample (recorded count − 1).
- `Freq`  in  8: step ratio, unsigned Q2.6. 64 = unity, 128 = up one octave, 32 = down one octave.
- `Src_Addr`  out  ADDR_W: read address to the recording RAM. The RAM is synchronous with 1-cycle read latency.
- `Src_Data`  in  DATA_W: read data, valid the cycle after `Src_Addr`.
- `Dst_Addr`  out  ADDR_W: write address to the playback RAM.
- `Dst_Data`  out  DATA_W: write data.
- `Dst_We`  out  1: write strobe, one cycle per output sample.
- `Busy`  out  1: high in every state except IDLE.
- `Done_Shift`  out  1: one-cycle pulse when the pass ends.
- `Out_Length`  out  ADDR_W: index of the last written sample; valid from `Done_Shift` until the next `Start`.

## Operation
- States:
  - IDLE
  - RD0: `Src_Addr` = i.
  - RD1: `Src_Addr` = min(i+1, Length); capture s0.
  - CALC: capture s1; compute y.
  - WR: `Dst_We`=1, `Dst_Addr`=cnt, `Dst_Data`=y.
  - DONE
- IDLE→RD0 on `Start`. On that edge, latch `Length` and `step`: step = `Freq`, except `Freq`=0 gives step=1. Also clear pos=0 and cnt=0.
- pos is an unsigned accumulator of ADDR_W+1+FRAC_W = 24 bits. i = pos[23:6] (18 bits), frac = pos[5:0]. The extra integer bit guarantees no wrap.
- Interpolation uses signed arithmetic only: d = s1 − s0 (17 bits), p = d·frac (24 bits), y = s0 + (p >>> 6), an arithmetic shift (floor). y always lies between s0 and s1, so no saturation is needed.
- At end of buffer (i = Length) the read is clamped, giving s1 = s0 and y = s0.
- WR→next state, on the same edge that writes:
  - pos += step, cnt += 1.
  - Go to DONE if the new i > latched Length, or if cnt was 2^ADDR_W−2 (destination full: last legal address written).
  - Otherwise go to RD0.
- DONE: `Done_Shift`=1 for exactly one cycle, `Out_Length` = cnt−1 (registered), then IDLE.
- `Start` outside IDLE is ignored. Changes to `Freq` or `Length` mid-pass are ignored because both are latched.

## Timing
- Every output is registered. Reset values: all of `Src_Addr`, `Dst_Addr`, `Dst_Data`, `Out_Length` are 0; all of `Dst_We`, `Busy`, `Done_Shift` are 0; state is IDLE; pos and cnt are 0.
- Throughput is 4 cycles per output sample.
- If `Start` is sampled at edge 0, the first `Dst_We` is high in the cycle after edge 4 and later writes follow every 4 cycles. `Done_Shift` is high in the cycle after the last WR.
- For N outputs, `Done_Shift` asserts at edge 4N+1 and `Busy` drops at edge 4N+2.
- `Busy` rises at edge 0+1, the first cycle of RD0.
- `Reset` mid-pass returns the block immediately to IDLE with all outputs at reset values. Partial RAM contents are don't-care, and no `Done_Shift` is issued.

## Structure
- Shared package `veritune_pkg`:
  - sample/address widths
  - `UNITY_STEP`=64, `FRAC_W`
  - `MAX_LEN`=2^17−2
  - state encodings, one-hot 6 bits, matching the top state machine's one-hot style
- One natural sub-module: `veritune_lerp`, a combinational s0, s1, frac → y function. It is shared with future real-time playback.

## Test plan
- Unity: Freq=64, Length=3, src=100,200,300,400 → dst=100,200,300,400; Out_Length=3; Done_Shift at edge 17.
- Up-octave: Freq=128, Length=7, src=0,10,…,70 → dst=0,20,40,60; Out_Length=3.
- Down-octave with end clamp: Freq=32, Length=1, src=0,100 → dst=0,50,100,100; Out_Length=3.
- Signed/floor: Freq=32, Length=1, src=0,−1 → dst[1]=−1. With src=−100,100, dst[1]=0.
- Freq=0 treated as step 1: Length=0, src=500 → 64 writes of 500; Out_Length=63.
- Reset asserted during the 2nd WR → next cycle Busy=0, Dst_We=0; no Done_Shift. A fresh Start then runs the unity case correctly.

Source files
------------

// File: rtl/veritune_pkg.sv
// Shared constants and state encodings for the Veritune datapath.
package veritune_pkg;

  localparam int unsigned SAMPLE_ADDR_W = 17;
  localparam int unsigned SAMPLE_DATA_W = 16;
  localparam int unsigned FRAC_W        = 6;
  localparam int unsigned FREQ_W        = 8;
  localparam int unsigned UNITY_STEP    = 1 << FRAC_W;
  localparam int unsigned MAX_LEN       = (1 << SAMPLE_ADDR_W) - 2;

  // One-hot, matching the top-level state machine style.
  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_RD0  = 6'b000010,
    ST_RD1  = 6'b000100,
    ST_CALC = 6'b001000,
    ST_WR   = 6'b010000,
    ST_DONE = 6'b100000
  } shift_state_t;

endpackage

// File: rtl/veritune_lerp.sv
// Linear interpolation between two signed samples: y = s0 + floor((s1-s0)*frac / 2^FRAC_W).
module veritune_lerp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 6
) (
  input  logic signed [DATA_W-1:0] S0,
  input  logic signed [DATA_W-1:0] S1,
  input  logic        [FRAC_W-1:0] Frac,
  output logic signed [DATA_W-1:0] Y
);

  localparam int unsigned EXT_W = DATA_W + FRAC_W + 2;

  logic signed [EXT_W-1:0] s0_ext;
  logic signed [EXT_W-1:0] diff;
  logic signed [EXT_W-1:0] frac_ext;
  logic signed [EXT_W-1:0] prod;
  logic signed [EXT_W-1:0] sum;

  // Signed difference, scaled by frac, floored by arithmetic shift.
  always_comb begin
    s0_ext   = EXT_W'(S0);
    diff     = EXT_W'(S1) - s0_ext;
    frac_ext = $signed({{(EXT_W-FRAC_W){1'b0}}, Frac});
    prod     = diff * frac_ext;
    sum      = s0_ext + (prod >>> FRAC_W);
    Y        = sum[DATA_W-1:0];
  end

endmodule

// File: rtl/veritune_resampler.sv
// Pitch-shift pass: reads the recording, resamples by Freq (Q2.6), writes playback RAM.
module veritune_resampler #(
  parameter int unsigned ADDR_W = veritune_pkg::SAMPLE_ADDR_W,
  parameter int unsigned DATA_W = veritune_pkg::SAMPLE_DATA_W,
  parameter int unsigned FRAC_W = veritune_pkg::FRAC_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic        [ADDR_W-1:0] Length,
  input  logic        [7:0]        Freq,
  output logic        [ADDR_W-1:0] Src_Addr,
  input  logic signed [DATA_W-1:0] Src_Data,
  output logic        [ADDR_W-1:0] Dst_Addr,
  output logic signed [DATA_W-1:0] Dst_Data,
  output logic                     Dst_We,
  output logic                     Busy,
  output logic                     Done_Shift,
  output logic        [ADDR_W-1:0] Out_Length
);

  import veritune_pkg::*;

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned POS_W = IDX_W + FRAC_W;
  localparam logic [ADDR_W-1:0] LAST_DST = ADDR_W'((1 << ADDR_W) - 2);

  shift_state_t               state;
  logic        [POS_W-1:0]    pos;
  logic        [POS_W-1:0]    pos_nxt;
  logic        [IDX_W-1:0]    idx;
  logic        [IDX_W-1:0]    idx_nxt;
  logic        [ADDR_W-1:0]   cnt;
  logic        [ADDR_W-1:0]   len_q;
  logic        [7:0]          step_q;
  logic signed [DATA_W-1:0]   s0_q;
  logic signed [DATA_W-1:0]   y;

  // Phase accumulator split into integer index and next-position lookahead.
  always_comb begin
    idx     = pos[POS_W-1:FRAC_W];
    pos_nxt = pos + POS_W'(step_q);
    idx_nxt = pos_nxt[POS_W-1:FRAC_W];
  end

  veritune_lerp #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_lerp (
    .S0   (s0_q),
    .S1   (Src_Data),
    .Frac (pos[FRAC_W-1:0]),
    .Y    (y)
  );

  // Sequencer. Outputs are registered decodes of the current state, so each
  // lags its state by one edge; s0/s1 are taken where the 1-cycle RAM
  // latency actually presents them (CALC and WR edges respectively).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      pos        <= '0;
      cnt        <= '0;
      len_q      <= '0;
      step_q     <= '0;
      s0_q       <= '0;
      Src_Addr   <= '0;
      Dst_Addr   <= '0;
      Dst_Data   <= '0;
      Dst_We     <= 1'b0;
      Busy       <= 1'b0;
      Done_Shift <= 1'b0;
      Out_Length <= '0;
    end else begin
      Busy       <= (state != ST_IDLE);
      Dst_We     <= (state == ST_WR);
      Done_Shift <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (Start) begin
            len_q  <= Length;
            step_q <= (Freq == '0) ? 8'd1 : Freq;
            pos    <= '0;
            cnt    <= '0;
            state  <= ST_RD0;
          end
        end
        ST_RD0: begin
          Src_Addr <= idx[ADDR_W-1:0];
          state    <= ST_RD1;
        end
        ST_RD1: begin
          Src_Addr <= (idx >= {1'b0, len_q}) ? len_q : ADDR_W'(idx + IDX_W'(1));
          state    <= ST_CALC;
        end
        ST_CALC: begin
          s0_q  <= Src_Data;
          state <= ST_WR;
        end
        ST_WR: begin
          Dst_Addr <= cnt;
          Dst_Data <= y;
          pos      <= pos_nxt;
          cnt      <= cnt + ADDR_W'(1);
          if ((idx_nxt > {1'b0, len_q}) || (cnt == LAST_DST)) begin
            state <= ST_DONE;
          end else begin
            state <= ST_RD0;
          end
        end
        ST_DONE: begin
          Out_Length <= cnt - ADDR_W'(1);
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_veritune_resampler.sv
// Randomised and directed checks of veritune_resampler against an arithmetic model.
module tb_veritune_resampler;

  logic               Clk;
  logic               Reset;
  logic               Start;
  logic        [16:0] Length;
  logic        [7:0]  Freq;
  logic        [16:0] Src_Addr;
  logic signed [15:0] Src_Data;
  logic        [16:0] Dst_Addr;
  logic signed [15:0] Dst_Data;
  logic               Dst_We;
  logic               Busy;
  logic               Done_Shift;
  logic        [16:0] Out_Length;

  veritune_resampler #(
    .ADDR_W (17),
    .DATA_W (16),
    .FRAC_W (6)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Length     (Length),
    .Freq       (Freq),
    .Src_Addr   (Src_Addr),
    .Src_Data   (Src_Data),
    .Dst_Addr   (Dst_Addr),
    .Dst_Data   (Dst_Data),
    .Dst_We     (Dst_We),
    .Busy       (Busy),
    .Done_Shift (Done_Shift),
    .Out_Length (Out_Length)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic signed [15:0] src_mem [0:255];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge Clk) begin
    cyc      <= cyc + 1;
    Src_Data <= src_mem[Src_Addr[7:0]];
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: output n sits at position n*step/64; stop once the index passes Length.
  task automatic build_expect(input int fq, input int ln, output int exp_q[$]);
    int step;
    exp_q = {};
    step = (fq == 0) ? 1 : fq;
    for (int n = 0; n < 4096; n++) begin
      int p, i, f, a, b, num, q;
      p = n * step;
      i = p / 64;
      f = p % 64;
      if (i > ln) break;
      a = src_mem[i];
      b = (i + 1 > ln) ? int'(src_mem[ln]) : int'(src_mem[i + 1]);
      num = (b - a) * f;
      q = (num >= 0) ? num / 64 : -((-num + 63) / 64);
      exp_q.push_back(a + q);
    end
  endtask

  task automatic run_pass(input string name, input int fq, input int ln,
                          input bit noise, input int abort_wr);
    int exp_q[$];
    int nexp, c0, k, widx, limit;
    bit done_seen, finished;
    build_expect(fq, ln, exp_q);
    nexp = exp_q.size();
    @(negedge Clk);
    Freq   = 8'(fq);
    Length = 17'(ln);
    Start  = 1'b1;
    c0 = cyc;
    widx = 0;
    done_seen = 1'b0;
    finished = 1'b0;
    limit = 4 * nexp + 20;
    for (int t = 0; t < limit; t++) begin
      @(negedge Clk);
      k = cyc - c0 - 1;
      if (!noise && k == 0) Start = 1'b0;
      if (noise && !done_seen) begin
        Freq   = 8'($urandom);
        Length = 17'($urandom);
      end
      if (k == 1) chk({name, " busy_rise"}, Busy, 1);
      if (Dst_We) begin
        if (widx < nexp) begin
          chk($sformatf("%s wr%0d_time", name, widx), k, 4 + 4 * widx);
          chk($sformatf("%s wr%0d_addr", name, widx), Dst_Addr, widx);
          chk($sformatf("%s wr%0d_data", name, widx), Dst_Data, exp_q[widx]);
        end else begin
          chk({name, " extra_write"}, widx, nexp - 1);
        end
        if (widx == abort_wr) begin
          Reset = 1'b1;
          #1;
          chk({name, " rst_busy"}, Busy, 0);
          chk({name, " rst_we"}, Dst_We, 0);
          chk({name, " rst_addr"}, Src_Addr, 0);
          Start = 1'b0;
          @(negedge Clk);
          Reset = 1'b0;
          for (int j = 0; j < 40; j++) begin
            @(negedge Clk);
            if (Done_Shift || Busy) done_seen = 1'b1;
          end
          chk({name, " no_done_after_reset"}, done_seen, 0);
          return;
        end
        widx++;
      end
      if (Done_Shift) begin
        if (!done_seen) begin
          chk({name, " done_edge"}, k, 4 * nexp + 1);
          chk({name, " out_length"}, Out_Length, nexp - 1);
        end
        done_seen = 1'b1;
        Start = 1'b0;
      end
      if (!Busy && k > 1) begin
        chk({name, " busy_fall"}, k, 4 * nexp + 2);
        finished = 1'b1;
        break;
      end
    end
    Start = 1'b0;
    chk({name, " finished"}, finished, 1);
    chk({name, " writes"}, widx, nexp);
    chk({name, " done_seen"}, done_seen, 1);
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    src_mem[0] = 16'(a);
    src_mem[1] = 16'(b);
    src_mem[2] = 16'(c);
    src_mem[3] = 16'(d);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) src_mem[i] = '0;
    Reset  = 1'b1;
    Start  = 1'b0;
    Freq   = '0;
    Length = '0;
    repeat (3) @(negedge Clk);
    chk("reset Src_Addr", Src_Addr, 0);
    chk("reset Dst_Addr", Dst_Addr, 0);
    chk("reset Dst_Data", Dst_Data, 0);
    chk("reset Out_Length", Out_Length, 0);
    chk("reset Dst_We", Dst_We, 0);
    chk("reset Busy", Busy, 0);
    chk("reset Done_Shift", Done_Shift, 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    load4(100, 200, 300, 400);
    run_pass("unity", 64, 3, 1'b0, -1);

    for (int i = 0; i < 8; i++) src_mem[i] = 16'(10 * i);
    run_pass("up_octave", 128, 7, 1'b0, -1);

    load4(0, 100, 0, 0);
    run_pass("down_clamp", 32, 1, 1'b0, -1);

    load4(0, -1, 0, 0);
    run_pass("floor_neg", 32, 1, 1'b0, -1);

    load4(-100, 100, 0, 0);
    run_pass("signed_mid", 32, 1, 1'b0, -1);

    load4(500, 0, 0, 0);
    run_pass("freq_zero", 0, 0, 1'b0, -1);

    load4(100, 200, 300, 400);
    run_pass("reset_mid", 64, 3, 1'b0, 1);
    run_pass("unity_again", 64, 3, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      int fq, ln;
      fq = $urandom_range(0, 255);
      ln = (fq < 8) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      for (int i = 0; i < 256; i++) src_mem[i] = 16'($urandom);
      run_pass($sformatf("rand%0d", r), fq, ln, r[0], -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
